// File: rtl/move_entry_pkg.sv
// Shared types and constants for the X move-entry block: FSM state encoding,
// reject codes, board width and the move evaluation helper.
package move_entry_pkg;

    localparam int BOARD_W = 9;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        EVAL       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_NOT_ONE_HOT = 2'b01;
    localparam logic [1:0] ERR_OCCUPIED    = 2'b10;
    localparam logic [1:0] ERR_GAME_OVER   = 2'b11;

    // Reject code for a requested square; game over outranks a malformed
    // request, which outranks an occupied square.
    function automatic logic [1:0] eval_move(
        input logic [BOARD_W-1:0] sw_v,
        input logic [BOARD_W-1:0] x_v,
        input logic [BOARD_W-1:0] o_v,
        input logic               game_over_v
    );
        logic one_hot;
        one_hot = (sw_v != '0) && ((sw_v & (sw_v - BOARD_W'(1))) == '0);
        if (game_over_v)
            return ERR_GAME_OVER;
        else if (!one_hot)
            return ERR_NOT_ONE_HOT;
        else if ((sw_v & (x_v | o_v)) != '0)
            return ERR_OCCUPIED;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/move_entry_btn_debounce.sv
// Two-flop synchronizer for the active-low pushbutton plus a saturating
// stable-cycle counter. The owning FSM decides when to clear or advance the
// counter, so the same block qualifies both presses and releases.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic cnt_clr,
    input  logic cnt_inc,
    output logic pressed,
    output logic cnt_last
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronize the raw button; reset value 1 means "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_reg <= 2'b11;
        else
            sync_reg <= {sync_reg[0], btn_n};
    end

    // Stable-cycle counter; holds at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_reg <= '0;
        else if (cnt_clr)
            cnt_reg <= '0;
        else if (cnt_inc && (cnt_reg != CNT_MAX))
            cnt_reg <= cnt_reg + CNT_W'(1);
    end

    assign pressed  = ~sync_reg[1];
    // High on the cycle that completes the required stable run.
    assign cnt_last = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/move_entry.sv
// Pushbutton move entry for player X: debounces the commit button, evaluates
// the requested square once per press and issues a one-cycle commit strobe or
// a reject code. Optional build macro MOVE_ENTRY_ERR_STICKY_EN keeps move_err
// latched until the next accepted move or reset.
import move_entry_pkg::*;

module move_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_n,
    input  logic [BOARD_W-1:0] sw,
    input  logic [BOARD_W-1:0] x,
    input  logic [BOARD_W-1:0] o,
    input  logic               game_over,
    output logic [BOARD_W-1:0] x_move,
    output logic               move_valid,
    output logic [1:0]         move_err,
    output logic               busy
);

    state_t     state_reg;
    logic       pressed;
    logic       cnt_last;
    logic       cnt_clr;
    logic       cnt_inc;
    logic [1:0] eval_code;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .cnt_clr  (cnt_clr),
        .cnt_inc  (cnt_inc),
        .pressed  (pressed),
        .cnt_last (cnt_last)
    );

    assign eval_code = eval_move(sw, x, o, game_over);

    // Counter control: advance while the qualifying level holds, clear on any
    // break in the run and in every state that is not counting.
    always_comb begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state_reg)
            PRESS_DB: begin
                if (pressed && !cnt_last) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            RELEASE_DB: begin
                if (!pressed && !cnt_last) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                cnt_inc = 1'b0;
            end
        endcase
    end

    // Press/evaluate/release sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            x_move     <= '0;
            move_valid <= 1'b0;
            move_err   <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            x_move     <= '0;
`ifdef MOVE_ENTRY_ERR_STICKY_EN
            move_err   <= move_err;
`else
            move_err   <= ERR_NONE;
`endif
            case (state_reg)
                IDLE: begin
                    if (pressed) begin
                        state_reg <= PRESS_DB;
                        busy      <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (cnt_last) begin
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    state_reg <= RELEASE_DB;
                    if (eval_code == ERR_NONE) begin
                        move_valid <= 1'b1;
                        x_move     <= sw;
                        move_err   <= ERR_NONE;
                    end else begin
                        move_err   <= eval_code;
                    end
                end
                RELEASE_DB: begin
                    if (!pressed && cnt_last) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry with DEBOUNCE_CYCLES = 4. Works in both the
// default build and with MOVE_ENTRY_ERR_STICKY_EN defined.
module tb_move_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b1;
    logic [8:0] sw = '0;
    logic [8:0] x = '0;
    logic [8:0] o = '0;
    logic       game_over = 1'b0;
    logic [8:0] x_move;
    logic       move_valid;
    logic [1:0] move_err;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    int         cyc = 0;
    int         strobe_cnt = 0;
    int         strobe_cyc = 0;
    logic [8:0] strobe_x = '0;
    int         err_cycles = 0;
    logic [1:0] last_err = '0;

    move_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .sw         (sw),
        .x          (x),
        .o          (o),
        .game_over  (game_over),
        .x_move     (x_move),
        .move_valid (move_valid),
        .move_err   (move_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and reject codes, sampled away from the active edge.
    always @(negedge clk) begin
        if (move_valid) begin
            strobe_cnt <= strobe_cnt + 1;
            strobe_cyc <= cyc;
            strobe_x   <= x_move;
        end
        if (move_err != 2'b00) begin
            err_cycles <= err_cycles + 1;
            last_err   <= move_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press with the given board, hold 12 cycles, release 12 cycles.
    task automatic run_move(input logic [8:0] sw_v, input logic [8:0] x_v,
                            input logic [8:0] o_v, input logic go_v);
        sw = sw_v; x = x_v; o = o_v; game_over = go_v;
        tick();
        btn_n = 1'b0;
        repeat (12) tick();
        btn_n = 1'b1;
        repeat (12) tick();
        $display("move sw=%03h x=%03h o=%03h go=%0b -> last_err=%0d strobes=%0d",
                 sw_v, x_v, o_v, go_v, last_err, strobe_cnt);
    endtask

    task automatic release_idle(input string tag);
        btn_n = 1'b1;
        repeat (12) tick();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_%s: busy=%0b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", move_valid); end
        if (x_move !== 9'h000)   begin fails++; $display("FAIL reset_xmove: got %03h expected 000", x_move); end
        if (move_err !== 2'b00)  begin fails++; $display("FAIL reset_err: got %0d expected 0", move_err); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
        $display("reset done at cycle %0d", cyc);
    endtask

    task automatic test_basic();
        int n, s0;
        sw = 9'h010; x = '0; o = '0; game_over = 1'b0;
        s0 = strobe_cnt;
        tick();
        n = cyc + 1;
        btn_n = 1'b0;
        repeat (12) tick();
        checks += 4;
        if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL basic_count: got %0d expected 1", strobe_cnt - s0); end
        if (strobe_cyc != n + 7)  begin fails++; $display("FAIL basic_latency: strobe at %0d expected %0d", strobe_cyc, n + 7); end
        if (strobe_x !== 9'h010)  begin fails++; $display("FAIL basic_xmove: got %03h expected 010", strobe_x); end
        if (busy !== 1'b1)        begin fails++; $display("FAIL basic_busy_held: got %0b expected 1", busy); end
        $display("basic press: strobe at %0d x_move=%03h", strobe_cyc, strobe_x);
        release_idle("basic");
    endtask

    task automatic test_bounce();
        int n, s0;
        sw = 9'h001; x = '0; o = '0; game_over = 1'b0;
        s0 = strobe_cnt;
        tick();
        n = cyc + 1;
        btn_n = 1'b0;
        repeat (3) tick();
        btn_n = 1'b1;
        tick();
        btn_n = 1'b0;
        repeat (40) tick();
        checks += 2;
        if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL bounce_count: got %0d expected 1", strobe_cnt - s0); end
        if (strobe_cyc != n + 11) begin fails++; $display("FAIL bounce_latency: strobe at %0d expected %0d", strobe_cyc, n + 11); end
        $display("bounce press: strobe at %0d", strobe_cyc);
        release_idle("bounce");
    endtask

    task automatic test_reject();
        int s0, e0;
        s0 = strobe_cnt;
        // Two bits set.
        e0 = err_cycles;
        run_move(9'h011, 9'h000, 9'h000, 1'b0);
        checks += 3;
        if (last_err !== 2'b01) begin fails++; $display("FAIL rej_two_bits: err %0d expected 1", last_err); end
        if (strobe_cnt != s0)   begin fails++; $display("FAIL rej_two_bits_strobe: %0d strobes expected 0", strobe_cnt - s0); end
`ifdef MOVE_ENTRY_ERR_STICKY_EN
        if (move_err !== 2'b01) begin fails++; $display("FAIL rej_two_bits_hold: err %0d expected 1", move_err); end
`else
        if (err_cycles - e0 != 1) begin fails++; $display("FAIL rej_two_bits_width: %0d cycles expected 1", err_cycles - e0); end
`endif
        // No bit set.
        e0 = err_cycles;
        run_move(9'h000, 9'h000, 9'h000, 1'b0);
        checks++;
        if (last_err !== 2'b01) begin fails++; $display("FAIL rej_zero: err %0d expected 1", last_err); end
        // Occupied by X.
        e0 = err_cycles;
        run_move(9'h001, 9'h001, 9'h000, 1'b0);
        checks += 2;
        if (last_err !== 2'b10) begin fails++; $display("FAIL rej_occ_x: err %0d expected 2", last_err); end
`ifdef MOVE_ENTRY_ERR_STICKY_EN
        if (move_err !== 2'b10) begin fails++; $display("FAIL rej_occ_x_hold: err %0d expected 2", move_err); end
`else
        if (err_cycles - e0 != 1) begin fails++; $display("FAIL rej_occ_x_width: %0d cycles expected 1", err_cycles - e0); end
`endif
        // Occupied by O.
        run_move(9'h004, 9'h000, 9'h004, 1'b0);
        checks += 2;
        if (last_err !== 2'b10) begin fails++; $display("FAIL rej_occ_o: err %0d expected 2", last_err); end
        if (strobe_cnt != s0)   begin fails++; $display("FAIL rej_strobes: %0d strobes expected 0", strobe_cnt - s0); end
    endtask

    task automatic test_game_over();
        int s0;
        s0 = strobe_cnt;
        run_move(9'h001, 9'h000, 9'h000, 1'b1);
        checks++;
        if (last_err !== 2'b11) begin fails++; $display("FAIL go_empty: err %0d expected 3", last_err); end
        run_move(9'h000, 9'h000, 9'h000, 1'b0);
        run_move(9'h011, 9'h000, 9'h000, 1'b1);
        checks += 2;
        if (last_err !== 2'b11) begin fails++; $display("FAIL go_over_onehot: err %0d expected 3", last_err); end
        if (strobe_cnt != s0)   begin fails++; $display("FAIL go_strobes: %0d strobes expected 0", strobe_cnt - s0); end
        game_over = 1'b0;
    endtask

    task automatic test_sw_outside_eval();
        int n, s0;
        sw = 9'h003; x = '0; o = '0; game_over = 1'b0;
        s0 = strobe_cnt;
        tick();
        n = cyc + 1;
        btn_n = 1'b0;
        repeat (3) tick();
        sw = 9'h100;
        repeat (5) tick();
        sw = 9'h001;
        repeat (4) tick();
        checks += 4;
        if (strobe_cnt - s0 != 1) begin fails++; $display("FAIL swchg_count: got %0d expected 1", strobe_cnt - s0); end
        if (strobe_x !== 9'h100)  begin fails++; $display("FAIL swchg_xmove: got %03h expected 100", strobe_x); end
        if (strobe_cyc != n + 7)  begin fails++; $display("FAIL swchg_latency: strobe at %0d expected %0d", strobe_cyc, n + 7); end
        if (move_err !== 2'b00)   begin fails++; $display("FAIL swchg_err_clear: err %0d expected 0", move_err); end
        $display("sw change press: strobe at %0d x_move=%03h", strobe_cyc, strobe_x);
        release_idle("swchg");
    endtask

    task automatic test_hold_repress();
        int n, s0;
        sw = 9'h080; x = '0; o = '0; game_over = 1'b0;
        s0 = strobe_cnt;
        tick();
        n = cyc + 1;
        btn_n = 1'b0;
        repeat (100) tick();
        btn_n = 1'b1;
        repeat (4) tick();
        btn_n = 1'b0;
        repeat (20) tick();
        checks += 3;
        if (strobe_cnt - s0 != 2)   begin fails++; $display("FAIL hold_count: got %0d expected 2", strobe_cnt - s0); end
        if (strobe_cyc != n + 111)  begin fails++; $display("FAIL hold_second_latency: strobe at %0d expected %0d", strobe_cyc, n + 111); end
        if (move_err !== 2'b00)     begin fails++; $display("FAIL hold_err: err %0d expected 0", move_err); end
        $display("hold/repress: strobes=%0d last at %0d", strobe_cnt - s0, strobe_cyc);
        // A 3-cycle release is too short to re-arm.
        s0 = strobe_cnt;
        btn_n = 1'b1;
        repeat (3) tick();
        btn_n = 1'b0;
        repeat (20) tick();
        checks++;
        if (strobe_cnt != s0) begin fails++; $display("FAIL short_release: %0d strobes expected 0", strobe_cnt - s0); end
        release_idle("hold");
    endtask

    task automatic test_reset_eval();
        int n, s0, e0;
        sw = 9'h002; x = '0; o = '0; game_over = 1'b0;
        s0 = strobe_cnt;
        e0 = err_cycles;
        tick();
        n = cyc + 1;
        btn_n = 1'b0;
        repeat (7) tick();
        #3;
        reset = 1'b1;
        #1;
        checks += 2;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL rst_eval_valid: got %0b expected 0", move_valid); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL rst_eval_busy: got %0b expected 0", busy); end
        tick();
        #3;
        reset = 1'b0;
        repeat (20) tick();
        checks += 3;
        if (strobe_cnt - s0 != 1)  begin fails++; $display("FAIL rst_eval_count: got %0d expected 1", strobe_cnt - s0); end
        if (strobe_cyc != n + 15)  begin fails++; $display("FAIL rst_eval_latency: strobe at %0d expected %0d", strobe_cyc, n + 15); end
        if (err_cycles != e0)      begin fails++; $display("FAIL rst_eval_err: %0d err cycles expected 0", err_cycles - e0); end
        $display("reset at EVAL: strobe at %0d", strobe_cyc);
        release_idle("rst_eval");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_reject();
        test_game_over();
        test_sw_outside_eval();
        test_hold_repress();
        test_reset_eval();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles required to accept a press or release; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port btn_n, input, 1, asynchronous active-low commit pushbutton.
REQ-005 The block SHALL have port sw, input, 9, requested X square, bit i = square i.
REQ-006 The block SHALL have port x, input, 9, current X occupancy.
REQ-007 The block SHALL have port o, input, 9, current O occupancy.
REQ-008 The block SHALL have port game_over, input, 1, high when any win line is active.
REQ-009 The block SHALL have port x_move, output, 9, committed square, one-hot while move_valid is high, else zero.
REQ-010 The block SHALL have port move_valid, output, 1, one-cycle commit strobe to the game-state stage.
REQ-011 The block SHALL have port move_err, output, 2, reject code: 00 none, 01 not one-hot, 10 occupied, 11 game over.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 btn_n SHALL pass through a two-flop synchronizer before any use; "pressed" means synchronized value 0.
REQ-014 The FSM SHALL have states IDLE, PRESS_DB, EVAL, RELEASE_DB.
REQ-015 IDLE -> PRESS_DB when pressed; the debounce counter clears on entry.
REQ-016 PRESS_DB SHALL increment the counter each pressed cycle, return to IDLE on any unpressed cycle, and go to EVAL when the count reaches DEBOUNCE_CYCLES.
REQ-017 EVAL SHALL last exactly one cycle, sample sw, x, o and game_over, and go to RELEASE_DB.
REQ-018 Reject priority in EVAL SHALL be: game_over -> 11; sw not exactly one bit set (including zero) -> 01; (sw & (x|o)) nonzero -> 10; otherwise accept.
REQ-019 On accept, x_move = sampled sw and move_valid = 1 SHALL be registered outputs for exactly the cycle after EVAL, with move_err = 00.
REQ-020 On reject, move_valid SHALL stay 0, x_move 0, and move_err SHALL take the code on the cycle after EVAL.
REQ-021 With DEBOUNCE_CYCLES = D and btn_n low from edge N onward, move_valid SHALL be high at edge N+D+3.
REQ-022 RELEASE_DB SHALL require D consecutive unpressed cycles before IDLE; a pressed cycle clears the counter; a held button SHALL never produce a second commit.
REQ-023 sw changes outside EVAL SHALL have no effect.
REQ-024 The counter SHALL saturate and SHALL not wrap.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, counter 0, synchronizer flops to 1 (released), x_move 0, move_valid 0, move_err 00, busy 0.
REQ-026 Reset asserted mid-press or mid-EVAL SHALL discard the pending move; after reset deassertion a still-held button SHALL produce exactly one commit, D+3 cycles after the first synchronized low is sampled.

Configuration
REQ-027 With MOVE_ENTRY_ERR_STICKY_EN defined, move_err SHALL hold its code until the next accepted move or reset.
REQ-028 Without MOVE_ENTRY_ERR_STICKY_EN, move_err SHALL be nonzero for exactly one cycle per reject.

Structure
REQ-029 The shared package SHALL hold the FSM state enum, the move_err code constants, and the board width constant 9.
REQ-030 The synchronizer plus debounce counter SHALL be one sub-module, btn_debounce, reused for both press and release qualification.

Verification (D = 4)
REQ-031 Reset, then btn_n low at edge 10 and held, with sw=9'h010, x=o=0: move_valid=1 and x_move=9'h010 at edge 17 only.
REQ-032 Bounce: btn_n low 3 cycles, high 1, then low held: the counter restarts and exactly one move_valid is issued.
REQ-033 sw=9'h011: move_err=01, no strobe; sw=9'h001 with x=9'h001: move_err=10.
REQ-034 game_over=1 with sw=9'h001 on an empty board: move_err=11, and the game-over code wins over a simultaneous not-one-hot sw.
REQ-035 Button held 100 cycles, then released 4 cycles, then pressed again: exactly two commits.
REQ-036 Reset pulse at the EVAL cycle: no strobe; with the button still held, one strobe 7 cycles after the first synchronized low; run in both macro builds to check move_err duration.
